variance_cache: RTL and testbench

VARIANCE_CACHE -- requirements
Module: variance_cache

---
 rtl/pkg_SQImageCache.sv | 6 +
 rtl/pkg_integralImageCache.sv | 6 +
 rtl/structs.sv | 22 ++
 rtl/variance_cache_pkg.sv | 14 +
 rtl/variance_cache_if.sv | 33 +++
 rtl/variance_cache_bank.sv | 50 +++++
 rtl/variance_cache.sv | 98 +++++++++
 tb/tb_variance_cache.sv | 270 +++++++++++++++++++++++++++
 8 files changed

// File: rtl/pkg_SQImageCache.sv
// Shared width of squared-integral-image samples used by the variance pipeline.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pkg_SQImageCache;
    localparam int SQImageDepth = 40;
endpackage

// File: rtl/pkg_integralImageCache.sv
// Shared width of integral-image samples used by the variance pipeline.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pkg_integralImageCache;
    localparam int integralImageDepth = 24;
endpackage

// File: rtl/structs.sv
// Shared read-port structs, bank-state enum and corner count for the variance cache.
// Latency: n/a (types only).
// Backpressure: n/a.
package structs;
    localparam int NUM_CORNERS = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    typedef struct packed {
        logic [2:0] raddr;
        logic [2:0] raddrSQ;
    } struct_varianceCache_Read_in;

    typedef struct packed {
        logic [pkg_integralImageCache::integralImageDepth-1:0] q;
        logic [pkg_SQImageCache::SQImageDepth-1:0]             qSQ;
    } struct_varianceCache_Read_out;
endpackage

// File: rtl/variance_cache_pkg.sv
// Local data types and address helper for the variance cache slice.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package variance_cache_pkg;
    import structs::*;

    typedef logic [pkg_integralImageCache::integralImageDepth-1:0] int_dat_t;
    typedef logic [pkg_SQImageCache::SQImageDepth-1:0]             sq_dat_t;

    // Read addresses 4..7 have no backing entry and read as zero.
    function automatic logic in_range(input logic [2:0] addr);
        return addr < 3'(NUM_CORNERS);
    endfunction
endpackage

// File: rtl/variance_cache_if.sv
// Bundle of write handshake, window handshake and both read ports of the cache.
// Latency: n/a (wires only).
// Backpressure: wr_ready gates writes; win_valid/win_release hand windows over.
interface variance_cache_if;
    import variance_cache_pkg::*;
    import structs::*;

    logic                         wr_valid;
    logic                         wr_ready;
    logic [1:0]                   wr_addr;
    int_dat_t                     wr_data;
    sq_dat_t                      wr_dataSQ;
    logic                         wr_last;
    struct_varianceCache_Read_in  vcrA_in;
    struct_varianceCache_Read_out vcrA_out;
    struct_varianceCache_Read_in  vcrB_in;
    struct_varianceCache_Read_out vcrB_out;
    logic                         win_valid;
    logic                         dblBuf;
    logic                         win_release;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_dataSQ, wr_last,
        output vcrA_in, vcrB_in, win_release,
        input  wr_ready, vcrA_out, vcrB_out, win_valid, dblBuf
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_dataSQ, wr_last,
        input  vcrA_in, vcrB_in, win_release,
        output wr_ready, vcrA_out, vcrB_out, win_valid, dblBuf
    );
endinterface

// File: rtl/variance_cache_bank.sv
// One bank of 4 integral + 4 squared corner entries with a registered read port.
// Latency: read data valid 1 cycle after address; reads see pre-write contents.
// Backpressure: none; clear has priority over write (the two never coincide).
module variance_cache_bank
    import variance_cache_pkg::*;
    import structs::*;
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         wr_en,
    input  logic [1:0]                   wr_addr,
    input  int_dat_t                     wr_data,
    input  sq_dat_t                      wr_dataSQ,
    input  logic                         clr,
    input  struct_varianceCache_Read_in  rd_in,
    output struct_varianceCache_Read_out rd_out
);

    int_dat_t mem_int [NUM_CORNERS];
    sq_dat_t  mem_sq  [NUM_CORNERS];

    // Corner storage: wiped on release so a short window reads 0 in unwritten slots.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CORNERS; i++) begin
                mem_int[i] <= '0;
                mem_sq[i]  <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NUM_CORNERS; i++) begin
                mem_int[i] <= '0;
                mem_sq[i]  <= '0;
            end
        end else if (wr_en) begin
            mem_int[wr_addr] <= wr_data;
            mem_sq[wr_addr]  <= wr_dataSQ;
        end
    end

    // Registered read; integral and squared halves have independent addresses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_out <= '0;
        end else begin
            rd_out.q   <= in_range(rd_in.raddr)   ? mem_int[rd_in.raddr[1:0]]  : '0;
            rd_out.qSQ <= in_range(rd_in.raddrSQ) ? mem_sq[rd_in.raddrSQ[1:0]] : '0;
        end
    end

endmodule

// File: rtl/variance_cache.sv
// Ping-pong corner cache: writer fills bank wbank while consumer reads window in rbank.
// Latency: window offered the cycle after wr_last; reads are 1-cycle registered.
// Backpressure: wr_ready drops while the write bank is FULL; win_release frees it.
module variance_cache
    import variance_cache_pkg::*;
    import structs::*;
(
    input  logic            clk,
    input  logic            resetn,
    variance_cache_if.slave bus
);

    bank_state_t state [2];
    logic        wbank;
    logic        rbank;
    logic        accept;
    logic        release_go;
    logic [1:0]  wr_en;
    logic [1:0]  clr;

    assign bus.wr_ready  = (state[wbank] != FULL);
    assign bus.win_valid = (state[rbank] == FULL);
    assign bus.dblBuf    = rbank;

    assign accept     = bus.wr_valid & bus.wr_ready;
    assign release_go = bus.win_release & bus.win_valid;

    // Steer the accepted write and the release to their banks; FULL keeps them apart.
    always_comb begin
        wr_en        = '0;
        clr          = '0;
        wr_en[wbank] = accept;
        clr[rbank]   = release_go;
    end

    // Per-bank lifecycle: EMPTY -> FILLING -> FULL on wr_last, back to EMPTY on release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (clr[b]) begin
                    state[b] <= EMPTY;
                end else if (wr_en[b]) begin
                    if (bus.wr_last) begin
                        state[b] <= FULL;
                    end else if (state[b] == EMPTY) begin
                        state[b] <= FILLING;
                    end
                end
            end
        end
    end

    // Write pointer advances once a window is closed by wr_last.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wbank <= 1'b0;
        end else if (accept && bus.wr_last) begin
            wbank <= ~wbank;
        end
    end

    // Read pointer advances once the consumer hands the offered window back.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rbank <= 1'b0;
        end else if (release_go) begin
            rbank <= ~rbank;
        end
    end

    variance_cache_bank u_bank_a (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en     (wr_en[0]),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .wr_dataSQ (bus.wr_dataSQ),
        .clr       (clr[0]),
        .rd_in     (bus.vcrA_in),
        .rd_out    (bus.vcrA_out)
    );

    variance_cache_bank u_bank_b (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en     (wr_en[1]),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .wr_dataSQ (bus.wr_dataSQ),
        .clr       (clr[1]),
        .rd_in     (bus.vcrB_in),
        .rd_out    (bus.vcrB_out)
    );

endmodule

// File: tb/tb_variance_cache.sv
// Bench for variance_cache: directed scenarios plus random traffic vs a window-level model.
// Latency: inputs driven on negedge, outputs sampled on the following negedge.
// Backpressure: model predicts wr_ready / win_valid from bank occupancy.
module tb_variance_cache;
    import variance_cache_pkg::*;
    import structs::*;

    localparam int          IW    = pkg_integralImageCache::integralImageDepth;
    localparam int          SW    = pkg_SQImageCache::SQImageDepth;
    localparam logic [63:0] IMASK = (64'd1 << IW) - 64'd1;
    localparam logic [63:0] SMASK = (64'd1 << SW) - 64'd1;
    localparam int          S_EMPTY = 0;
    localparam int          S_FILL  = 1;
    localparam int          S_FULL  = 2;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    variance_cache_if bus();

    variance_cache dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Window-level model: two banks of corners, occupancy per bank, two pointers.
    logic [63:0] m_int [2][4];
    logic [63:0] m_sq  [2][4];
    int          m_state [2];
    int          m_wb;
    int          m_rb;

    int v35  [4] = '{10, 3, 4, 1};
    int v35s [4] = '{100, 9, 16, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_rd(input int bank, input int a, input bit sq);
        if (a >= 4) return 64'd0;
        return sq ? m_sq[bank][a] : m_int[bank][a];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 4; a++) begin
                m_int[b][a] = 64'd0;
                m_sq[b][a]  = 64'd0;
            end
            m_state[b] = S_EMPTY;
        end
        m_wb = 0;
        m_rb = 0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".wr_ready"},  64'(bus.wr_ready),  64'(m_state[m_wb] != S_FULL));
        chk({tag, ".win_valid"}, 64'(bus.win_valid), 64'(m_state[m_rb] == S_FULL));
        chk({tag, ".dblBuf"},    64'(bus.dblBuf),    64'(m_rb));
    endtask

    task automatic clear_inputs();
        bus.wr_valid        = 1'b0;
        bus.wr_addr         = 2'd0;
        bus.wr_data         = '0;
        bus.wr_dataSQ       = '0;
        bus.wr_last         = 1'b0;
        bus.win_release     = 1'b0;
        bus.vcrA_in.raddr   = 3'd0;
        bus.vcrA_in.raddrSQ = 3'd0;
        bus.vcrB_in.raddr   = 3'd0;
        bus.vcrB_in.raddrSQ = 3'd0;
    endtask

    // One clock of traffic: optional write, optional release, reads on both ports.
    task automatic step(input bit wv, input int wa, input logic [63:0] wd, input logic [63:0] ws,
                        input bit wl, input bit rel, input int raA, input int rsA,
                        input int raB, input int rsB, input string tag);
        logic [63:0] eqa, esa, eqb, esb;
        int wbk, rbk;
        bit acc, go;
        bus.wr_valid        = wv;
        bus.wr_addr         = 2'(wa);
        bus.wr_data         = IW'(wd);
        bus.wr_dataSQ       = SW'(ws);
        bus.wr_last         = wl;
        bus.win_release     = rel;
        bus.vcrA_in.raddr   = 3'(raA);
        bus.vcrA_in.raddrSQ = 3'(rsA);
        bus.vcrB_in.raddr   = 3'(raB);
        bus.vcrB_in.raddrSQ = 3'(rsB);
        #1;
        wbk = m_wb;
        rbk = m_rb;
        acc = wv && (m_state[wbk] != S_FULL);
        go  = rel && (m_state[rbk] == S_FULL);
        chk({tag, ".pre_wr_ready"}, 64'(bus.wr_ready), 64'(m_state[wbk] != S_FULL));
        eqa = exp_rd(0, raA, 1'b0);
        esa = exp_rd(0, rsA, 1'b1);
        eqb = exp_rd(1, raB, 1'b0);
        esb = exp_rd(1, rsB, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.wr_valid    = 1'b0;
        bus.wr_last     = 1'b0;
        bus.win_release = 1'b0;
        if (go) begin
            for (int a = 0; a < 4; a++) begin
                m_int[rbk][a] = 64'd0;
                m_sq[rbk][a]  = 64'd0;
            end
            m_state[rbk] = S_EMPTY;
            m_rb = 1 - rbk;
        end
        if (acc) begin
            m_int[wbk][wa] = wd & IMASK;
            m_sq[wbk][wa]  = ws & SMASK;
            if (wl) begin
                m_state[wbk] = S_FULL;
                m_wb = 1 - wbk;
            end else if (m_state[wbk] == S_EMPTY) begin
                m_state[wbk] = S_FILL;
            end
        end
        chk({tag, ".qA"},   64'(bus.vcrA_out.q),   eqa);
        chk({tag, ".qSQA"}, 64'(bus.vcrA_out.qSQ), esa);
        chk({tag, ".qB"},   64'(bus.vcrB_out.q),   eqb);
        chk({tag, ".qSQB"}, 64'(bus.vcrB_out.qSQ), esb);
        chk_status(tag);
    endtask

    task automatic idle_read(input int a, input string tag);
        step(1'b0, 0, 64'd0, 64'd0, 1'b0, 1'b0, a, a, a, a, tag);
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        #1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.wr_ready",  64'(bus.wr_ready),     64'd1);
        chk("rst.win_valid", 64'(bus.win_valid),    64'd0);
        chk("rst.dblBuf",    64'(bus.dblBuf),       64'd0);
        chk("rst.qA",        64'(bus.vcrA_out.q),   64'd0);
        chk("rst.qSQA",      64'(bus.vcrA_out.qSQ), 64'd0);
        chk("rst.qB",        64'(bus.vcrB_out.q),   64'd0);
        resetn = 1'b1;
    endtask

    initial begin
        logic [63:0] rd, rs;
        do_reset();

        // Single window into A, read back on port A.
        for (int i = 0; i < 4; i++)
            step(1'b1, i, 64'(v35[i]), 64'(v35s[i]), i == 3, 1'b0, 0, 0, 0, 0, "win35.wr");
        chk("win35.win_valid", 64'(bus.win_valid), 64'd1);
        chk("win35.dblBuf",    64'(bus.dblBuf),    64'd0);
        for (int i = 0; i < 4; i++) begin
            idle_read(i, "win35.rd");
            chk("win35.qA",   64'(bus.vcrA_out.q),   64'(v35[i]));
            chk("win35.qSQA", 64'(bus.vcrA_out.qSQ), 64'(v35s[i]));
        end

        // Back-pressure: B filled too, further writes refused, contents untouched.
        for (int i = 0; i < 4; i++) begin
            rd = {$urandom, $urandom};
            rs = {$urandom, $urandom};
            step(1'b1, i, rd, rs, i == 3, 1'b0, 0, 0, 0, 0, "bp.fillB");
        end
        chk("bp.wr_ready", 64'(bus.wr_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i, 64'hABCD, 64'h1234, 1'b1, 1'b0, i, i, i, i, "bp.reject");
            chk("bp.qA_kept", 64'(bus.vcrA_out.q), 64'(v35[i]));
        end

        // Ping-pong: release A, B becomes the offered window, A is blank and writable.
        step(1'b0, 0, 64'd0, 64'd0, 1'b0, 1'b1, 0, 0, 0, 0, "pp.rel");
        chk("pp.win_valid", 64'(bus.win_valid), 64'd1);
        chk("pp.dblBuf",    64'(bus.dblBuf),    64'd1);
        chk("pp.wr_ready",  64'(bus.wr_ready),  64'd1);
        for (int i = 0; i < 4; i++) begin
            idle_read(i, "pp.rdA");
            chk("pp.qA_zero",   64'(bus.vcrA_out.q),   64'd0);
            chk("pp.qSQA_zero", 64'(bus.vcrA_out.qSQ), 64'd0);
        end
        step(1'b1, 0, 64'd77, 64'd770, 1'b0, 1'b0, 0, 0, 0, 0, "pp.wrA");
        idle_read(0, "pp.rdA0");
        chk("pp.qA_new", 64'(bus.vcrA_out.q), 64'd77);

        // Close A, release B, then write B while releasing A in the same cycle.
        step(1'b1, 3, 64'd5, 64'd25, 1'b1, 1'b0, 0, 0, 0, 0, "sim.closeA");
        step(1'b0, 0, 64'd0, 64'd0, 1'b0, 1'b1, 0, 0, 0, 0, "sim.relB");
        chk("sim.dblBuf_A", 64'(bus.dblBuf), 64'd0);
        step(1'b1, 2, 64'd99, 64'd999, 1'b0, 1'b1, 0, 0, 0, 0, "sim.both");
        chk("sim.win_valid", 64'(bus.win_valid), 64'd0);
        chk("sim.dblBuf",    64'(bus.dblBuf),    64'd1);
        chk("sim.wr_ready",  64'(bus.wr_ready),  64'd1);
        for (int i = 0; i < 4; i++) begin
            idle_read(i, "sim.rd");
            chk("sim.qA_zero", 64'(bus.vcrA_out.q), 64'd0);
        end
        idle_read(2, "sim.rdB2");
        chk("sim.qB2",   64'(bus.vcrB_out.q),   64'd99);
        chk("sim.qSQB2", 64'(bus.vcrB_out.qSQ), 64'd999);

        // Out-of-range reads alias nothing; spurious release is ignored.
        step(1'b1, 1, 64'd55, 64'd550, 1'b0, 1'b0, 0, 0, 0, 0, "oor.wrB1");
        step(1'b0, 0, 64'd0, 64'd0, 1'b0, 1'b0, 7, 6, 5, 6, "oor.rd");
        chk("oor.qB5",   64'(bus.vcrB_out.q),   64'd0);
        chk("oor.qSQB6", 64'(bus.vcrB_out.qSQ), 64'd0);
        step(1'b0, 0, 64'd0, 64'd0, 1'b0, 1'b1, 1, 1, 1, 2, "spur.rel");
        chk("spur.win_valid", 64'(bus.win_valid),    64'd0);
        chk("spur.dblBuf",    64'(bus.dblBuf),       64'd1);
        chk("spur.qB1",       64'(bus.vcrB_out.q),   64'd55);
        chk("spur.qSQB2",     64'(bus.vcrB_out.qSQ), 64'd999);
        idle_read(1, "spur.rdB1");
        chk("spur.qB1_after", 64'(bus.vcrB_out.q), 64'd55);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rd = {$urandom, $urandom};
            rs = {$urandom, $urandom};
            step($urandom_range(3, 0) != 0, $urandom_range(3, 0), rd, rs,
                 $urandom_range(2, 0) == 0, $urandom_range(3, 0) == 0,
                 $urandom_range(7, 0), $urandom_range(7, 0),
                 $urandom_range(7, 0), $urandom_range(7, 0), "rand");
        end

        // Reset in the middle of filling A.
        do_reset();
        @(negedge clk);
        step(1'b1, 0, 64'd11, 64'd121, 1'b0, 1'b0, 0, 0, 0, 0, "mr.wr0");
        step(1'b1, 1, 64'd22, 64'd484, 1'b0, 1'b0, 0, 0, 0, 0, "mr.wr1");
        idle_read(1, "mr.rd1");
        chk("mr.q_before", 64'(bus.vcrA_out.q), 64'd22);
        resetn = 1'b0;
        #1;
        model_reset();
        chk("mr.win_valid", 64'(bus.win_valid),    64'd0);
        chk("mr.wr_ready",  64'(bus.wr_ready),     64'd1);
        chk("mr.qA",        64'(bus.vcrA_out.q),   64'd0);
        chk("mr.qSQA",      64'(bus.vcrA_out.qSQ), 64'd0);
        chk("mr.dblBuf",    64'(bus.dblBuf),       64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++)
            step(1'b1, i, 64'(40 + i), 64'(400 + i), i == 3, 1'b0, 1, 1, 1, 1, "mr.win");
        chk("mr.win_valid_after", 64'(bus.win_valid), 64'd1);
        chk("mr.dblBuf_after",    64'(bus.dblBuf),    64'd0);
        idle_read(1, "mr.rdA1");
        chk("mr.qA1_after", 64'(bus.vcrA_out.q), 64'd41);
        chk("mr.qB1_after", 64'(bus.vcrB_out.q), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
